app_scheduler: RTL and testbench
================================

// Module: app_scheduler
// PURPOSE
//  Top-level controller sharing buttons, 48-bit 7-seg display and alarm among N_APPS
//  application blocks (ladder game, clock, timer, ...). Menu selects an app; buttons
//  go only to the active app; its display is muxed to `out`. A pending app alarm
//  preempts the display until acknowledged. Sits between button debouncers and apps.
// PARAMETERS
//  N_APPS     4           number of applications, 2..8
//  DISP_W     48          display bus width per app (6 digits x 8 seg bits)
//  BLINK_CYC  25_000_000  clk cycles per blink half-period in ALERT (>=1)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  rst_n      in   1              synchronous active-low reset
//  up,down,left,right,enter,esc  in 1 each   debounced one-cycle button pulses
//  app_out    in   N_APPS*DISP_W  app i display at [i*DISP_W +: DISP_W]
//  app_alarm  in   N_APPS         level alarm request from app i
//  app_up,app_down,app_left,app_right,app_enter,app_esc  out N_APPS each  routed pulses
//  app_mode   out  N_APPS         one-hot run enable of active app (0 in MENU)
//  out        out  DISP_W         registered display to 7-seg driver (active-low segs)
//  alarm      out  1              registered OR of app_alarm
//  norm       out  1              1 while state==RUN
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at edge, any state): state=MENU, sel=0,
//    out=menu image of 0, alarm=0, norm=0, app_mode=0, all app_* pulses=0, blink cnt=0.
//  - Menu image: out[DISP_W-1:8]=all 1 (blank); out[7:0]=segment code of sel
//    (0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8).
//  - States MENU, RUN, ALERT; prev register records MENU/RUN on ALERT entry.
//  - MENU: right/down -> sel+1, wrap N_APPS-1->0; left/up -> sel-1, wrap 0->N_APPS-1.
//    Priority enter > esc > right/down > left/up. enter -> RUN, active=sel,
//    app_mode[sel]=1 next cycle. esc no effect. No pulses routed.
//  - RUN: each button pulse forwarded to active app with 1-cycle latency
//    (e.g. right at edge k -> app_right[active]=1 for cycle k+1 only).
//    esc not forwarded: -> MENU, sel=active, app_mode=0, other buttons same cycle dropped.
//    out=app_out slice of active (1-cycle latency). norm=1.
//  - Alarm entry: a = lowest index with app_alarm=1 excluding active app when in RUN.
//    If a exists in MENU/RUN -> ALERT; beats any button that cycle (button dropped).
//    Active app's own alarm in RUN never preempts; shown via its own display.
//  - ALERT: app_mode unchanged (active app keeps running). Blink cnt cleared on entry;
//    phase ON first: out=app_out[a]; OFF: out=all 1; toggle every BLINK_CYC cycles.
//    enter or esc -> forwarded as app_enter[a]/app_esc[a] 1 cycle later, return to prev.
//    Other buttons ignored. a re-evaluated each cycle (lowest pending). If app_alarm[a]
//    drops and none pending -> return to prev next edge, no pulse emitted.
//  - alarm = |app_alarm registered (1-cycle latency), independent of state.
//  - At most one app_* pulse bit set per vector; no pulses while rst_n=0.
// TESTING (N_APPS=4, BLINK_CYC=4)
//  1 Reset, 3x left -> sel 0->3->2->1; out[7:0]=F9; out[47:8]=all 1; norm=0.
//  2 sel=2, enter -> app_mode=4'b0100, norm=1; right -> app_right=4'b0100 one
//    cycle later; out follows app_out[2] with 1-cycle lag.
//  3 RUN app2, esc+up same cycle -> MENU, sel=2, app_mode=0, no app_esc/app_up pulse.
//  4 RUN app2, app_alarm=4'b1010 -> ALERT a=1; out alternates app_out[1]/all 1 every
//    4 cycles, ON first; enter -> app_enter=4'b0010, back to RUN app2.
//  5 MENU, app_alarm[3] rises same cycle as enter -> ALERT, enter dropped; app_alarm
//    clears unacked -> MENU next edge, no pulses; alarm tracks with 1-cycle lag.
//  6 rst_n=0 mid-ALERT -> all outputs at reset values next edge; state MENU, sel=0.

Source files
------------

// File: rtl/app_scheduler.sv
// app_scheduler: shares the buttons, the 7-segment display and the alarm line
// among N_APPS application blocks. A menu picks the active application. Button
// pulses are routed only to the active application, and its display is muxed
// to the output. A pending alarm from another application takes over the
// display with a blinking image until the user acknowledges it.
module app_scheduler #(
    parameter int N_APPS    = 4,
    parameter int DISP_W    = 48,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up,
    input  logic                       down,
    input  logic                       left,
    input  logic                       right,
    input  logic                       enter,
    input  logic                       esc,
    input  logic [N_APPS*DISP_W-1:0]   app_out,
    input  logic [N_APPS-1:0]          app_alarm,
    output logic [N_APPS-1:0]          app_up,
    output logic [N_APPS-1:0]          app_down,
    output logic [N_APPS-1:0]          app_left,
    output logic [N_APPS-1:0]          app_right,
    output logic [N_APPS-1:0]          app_enter,
    output logic [N_APPS-1:0]          app_esc,
    output logic [N_APPS-1:0]          app_mode,
    output logic [DISP_W-1:0]          out,
    output logic                       alarm,
    output logic                       norm
);

    localparam int SEL_W = $clog2(N_APPS);
    localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_APPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        ST_MENU,
        ST_RUN,
        ST_ALERT
    } state_t;

    state_t              state_q, state_d;
    state_t              prev_q, prev_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [DISP_W-1:0]   out_q, out_d;
    logic                alarm_q, alarm_d;
    logic                norm_q, norm_d;
    logic [N_APPS-1:0]   mode_q, mode_d;
    logic [N_APPS-1:0]   up_q, up_d;
    logic [N_APPS-1:0]   down_q, down_d;
    logic [N_APPS-1:0]   left_q, left_d;
    logic [N_APPS-1:0]   right_q, right_d;
    logic [N_APPS-1:0]   enter_q, enter_d;
    logic [N_APPS-1:0]   esc_q, esc_d;

    logic [N_APPS-1:0]   pend_mask;
    logic                pend_valid;
    logic [SEL_W-1:0]    pend_idx;

    // Seven-segment code (active-low) of the digit shown in the menu.
    function automatic logic [7:0] seg_code(input int s);
        logic [7:0] c;
        case (s)
            0:       c = 8'hC0;
            1:       c = 8'hF9;
            2:       c = 8'hA4;
            3:       c = 8'hB0;
            4:       c = 8'h99;
            5:       c = 8'h92;
            6:       c = 8'h82;
            7:       c = 8'hF8;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    function automatic logic [N_APPS-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [N_APPS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Lowest-index pending alarm; the running app's own alarm never counts.
    always_comb begin
        pend_mask = app_alarm;
        if ((state_q == ST_RUN) || ((state_q == ST_ALERT) && (prev_q == ST_RUN))) begin
            pend_mask[active_q] = 1'b0;
        end
        pend_valid = |pend_mask;
        pend_idx   = '0;
        for (int i = N_APPS - 1; i >= 0; i--) begin
            if (pend_mask[i]) begin
                pend_idx = SEL_W'(i);
            end
        end
    end

    // Next-state logic: menu navigation, button routing and alarm handling.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        sel_d    = sel_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        up_d     = '0;
        down_d   = '0;
        left_d   = '0;
        right_d  = '0;
        enter_d  = '0;
        esc_d    = '0;
        case (state_q)
            ST_MENU: begin
                if (pend_valid) begin
                    state_d = ST_ALERT;
                    prev_d  = ST_MENU;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else if (enter) begin
                    state_d  = ST_RUN;
                    active_d = sel_q;
                end else if (!esc) begin
                    if (right || down) begin
                        sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
                    end else if (left || up) begin
                        sel_d = (sel_q == '0) ? LAST_SEL : sel_q - 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pend_valid) begin
                    state_d = ST_ALERT;
                    prev_d  = ST_RUN;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                end else if (esc) begin
                    state_d = ST_MENU;
                    sel_d   = active_q;
                end else begin
                    if (up)    up_d    = one_hot(active_q);
                    if (down)  down_d  = one_hot(active_q);
                    if (left)  left_d  = one_hot(active_q);
                    if (right) right_d = one_hot(active_q);
                    if (enter) enter_d = one_hot(active_q);
                end
            end
            ST_ALERT: begin
                if (!pend_valid) begin
                    state_d = prev_q;
                end else if (enter || esc) begin
                    if (enter) enter_d = one_hot(pend_idx);
                    if (esc)   esc_d   = one_hot(pend_idx);
                    state_d = prev_q;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // Output images derived from the state being entered, so every output
    // register agrees with the state register after the same edge.
    always_comb begin
        alarm_d = |app_alarm;
        norm_d  = (state_d == ST_RUN);
        mode_d  = '0;
        if ((state_d == ST_RUN) || ((state_d == ST_ALERT) && (prev_d == ST_RUN))) begin
            mode_d = one_hot(active_d);
        end
        out_d = '1;
        case (state_d)
            ST_MENU:  out_d = {{(DISP_W-8){1'b1}}, seg_code(int'(sel_d))};
            ST_RUN:   out_d = app_out[int'(active_d)*DISP_W +: DISP_W];
            ST_ALERT: out_d = phase_d ? app_out[int'(pend_idx)*DISP_W +: DISP_W] : '1;
            default:  out_d = '1;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_MENU;
            prev_q   <= ST_MENU;
            sel_q    <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            out_q    <= {{(DISP_W-8){1'b1}}, seg_code(0)};
            alarm_q  <= 1'b0;
            norm_q   <= 1'b0;
            mode_q   <= '0;
            up_q     <= '0;
            down_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            enter_q  <= '0;
            esc_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            sel_q    <= sel_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
            alarm_q  <= alarm_d;
            norm_q   <= norm_d;
            mode_q   <= mode_d;
            up_q     <= up_d;
            down_q   <= down_d;
            left_q   <= left_d;
            right_q  <= right_d;
            enter_q  <= enter_d;
            esc_q    <= esc_d;
        end
    end

    assign out       = out_q;
    assign alarm     = alarm_q;
    assign norm      = norm_q;
    assign app_mode  = mode_q;
    assign app_up    = up_q;
    assign app_down  = down_q;
    assign app_left  = left_q;
    assign app_right = right_q;
    assign app_enter = enter_q;
    assign app_esc   = esc_q;

endmodule

// File: tb/tb_app_scheduler.sv
// tb_app_scheduler: directed scenarios followed by random traffic, every cycle
// checked against a behavioural model of the scheduler.
module tb_app_scheduler;

    localparam int NA    = 4;
    localparam int DW    = 48;
    localparam int BLINK = 4;

    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_UP    = 6'b100000;
    localparam logic [5:0] B_DOWN  = 6'b010000;
    localparam logic [5:0] B_LEFT  = 6'b001000;
    localparam logic [5:0] B_RIGHT = 6'b000100;
    localparam logic [5:0] B_ENTER = 6'b000010;
    localparam logic [5:0] B_ESC   = 6'b000001;

    localparam int W_MENU  = 0;
    localparam int W_RUN   = 1;
    localparam int W_ALERT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic               enter = 1'b0, esc = 1'b0;
    logic [NA*DW-1:0]   app_out = '0;
    logic [NA-1:0]      app_alarm = '0;
    logic [NA-1:0]      app_up, app_down, app_left, app_right, app_enter, app_esc;
    logic [NA-1:0]      app_mode;
    logic [DW-1:0]      out;
    logic               alarm;
    logic               norm;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int             m_where = W_MENU;
    int             m_back  = W_MENU;
    int             m_sel   = 0;
    int             m_act   = 0;
    int             m_ticks = 0;
    logic [DW-1:0]  e_out;
    logic [NA-1:0]  e_mode, e_up, e_down, e_left, e_right, e_enter, e_esc;
    logic           e_alarm, e_norm;
    logic [7:0]     seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    app_scheduler #(
        .N_APPS    (NA),
        .DISP_W    (DW),
        .BLINK_CYC (BLINK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .enter     (enter),
        .esc       (esc),
        .app_out   (app_out),
        .app_alarm (app_alarm),
        .app_up    (app_up),
        .app_down  (app_down),
        .app_left  (app_left),
        .app_right (app_right),
        .app_enter (app_enter),
        .app_esc   (app_esc),
        .app_mode  (app_mode),
        .out       (out),
        .alarm     (alarm),
        .norm      (norm)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int lowest_set(input logic [NA-1:0] v);
        for (int i = 0; i < NA; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [NA-1:0] cand;
        int            a;
        bit            on;
        e_up = '0; e_down = '0; e_left = '0; e_right = '0; e_enter = '0; e_esc = '0;
        if (!rst_n) begin
            m_where = W_MENU;
            m_back  = W_MENU;
            m_sel   = 0;
            m_act   = 0;
            m_ticks = 0;
            e_alarm = 1'b0;
            e_norm  = 1'b0;
            e_mode  = '0;
            e_out   = {{(DW-8){1'b1}}, seg_tab[0]};
            return;
        end
        cand = app_alarm;
        if (m_where == W_RUN || (m_where == W_ALERT && m_back == W_RUN)) cand[m_act] = 1'b0;
        a = lowest_set(cand);
        if (m_where == W_MENU) begin
            if (a >= 0) begin
                m_where = W_ALERT; m_back = W_MENU; m_ticks = 0;
            end else if (enter) begin
                m_where = W_RUN; m_act = m_sel;
            end else if (esc) begin
                m_sel = m_sel;
            end else if (right || down) begin
                m_sel = (m_sel + 1) % NA;
            end else if (left || up) begin
                m_sel = (m_sel + NA - 1) % NA;
            end
        end else if (m_where == W_RUN) begin
            if (a >= 0) begin
                m_where = W_ALERT; m_back = W_RUN; m_ticks = 0;
            end else if (esc) begin
                m_where = W_MENU; m_sel = m_act;
            end else begin
                if (up)    e_up[m_act]    = 1'b1;
                if (down)  e_down[m_act]  = 1'b1;
                if (left)  e_left[m_act]  = 1'b1;
                if (right) e_right[m_act] = 1'b1;
                if (enter) e_enter[m_act] = 1'b1;
            end
        end else begin
            if (a < 0) begin
                m_where = m_back;
            end else if (enter || esc) begin
                if (enter) e_enter[a] = 1'b1;
                if (esc)   e_esc[a]   = 1'b1;
                m_where = m_back;
            end else begin
                m_ticks++;
            end
        end
        e_alarm = |app_alarm;
        e_norm  = (m_where == W_RUN);
        e_mode  = '0;
        if (m_where == W_RUN || (m_where == W_ALERT && m_back == W_RUN)) e_mode[m_act] = 1'b1;
        if (m_where == W_MENU) begin
            e_out = {{(DW-8){1'b1}}, seg_tab[m_sel]};
        end else if (m_where == W_RUN) begin
            e_out = app_out[m_act*DW +: DW];
        end else begin
            on    = ((m_ticks / BLINK) % 2) == 0;
            e_out = on ? app_out[a*DW +: DW] : {DW{1'b1}};
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output.
    task automatic apply_stimulus(input string tag, input logic [5:0] btn, input logic [NA-1:0] alm);
        {up, down, left, right, enter, esc} = btn;
        app_alarm = alm;
        for (int i = 0; i < (NA*DW)/32; i++) app_out[i*32 +: 32] = $urandom;
        model_step();
        @(posedge clk);
        #1;
        check_output({tag, ".out"},    64'(out),      64'(e_out));
        check_output({tag, ".mode"},   64'(app_mode), 64'(e_mode));
        check_output({tag, ".norm"},   64'(norm),     64'(e_norm));
        check_output({tag, ".alarm"},  64'(alarm),    64'(e_alarm));
        check_output({tag, ".pulses"},
                     64'({app_up, app_down, app_left, app_right, app_enter, app_esc}),
                     64'({e_up, e_down, e_left, e_right, e_enter, e_esc}));
    endtask

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        logic [5:0]    rb;
        logic [NA-1:0] ra;
        $display("[TB] starting app_scheduler bench");
        #1;

        rst_n = 1'b0;
        apply_stimulus("rst0", B_NONE, 4'b0000);
        apply_stimulus("rst1", B_NONE, 4'b0000);
        check_output("rst_out", 64'(out), 64'({{(DW-8){1'b1}}, 8'hC0}));
        rst_n = 1'b1;

        apply_stimulus("s1_l1", B_LEFT, 4'b0000);
        check_output("s1_wrap", 64'(out[7:0]), 64'(8'hB0));
        apply_stimulus("s1_l2", B_LEFT, 4'b0000);
        apply_stimulus("s1_l3", B_LEFT, 4'b0000);
        check_output("s1_seg", 64'(out[7:0]), 64'(8'hF9));
        check_output("s1_blank", 64'(out[DW-1:8]), 64'({(DW-8){1'b1}}));

        apply_stimulus("s2_r", B_RIGHT, 4'b0000);
        apply_stimulus("s2_ent", B_ENTER, 4'b0000);
        check_output("s2_mode", 64'(app_mode), 64'(4'b0100));
        apply_stimulus("s2_right", B_RIGHT, 4'b0000);
        check_output("s2_rpulse", 64'(app_right), 64'(4'b0100));
        apply_stimulus("s2_idle", B_NONE, 4'b0000);
        check_output("s2_rdone", 64'(app_right), 64'(4'b0000));

        apply_stimulus("s3_escup", B_ESC | B_UP, 4'b0000);
        check_output("s3_seg", 64'(out[7:0]), 64'(8'hA4));
        check_output("s3_noesc", 64'({app_esc, app_up}), 64'(8'h00));

        apply_stimulus("s4_ent", B_ENTER, 4'b0000);
        apply_stimulus("s4_alm", B_NONE, 4'b1010);
        check_output("s4_on", 64'(out), 64'(app_out[1*DW +: DW]));
        check_output("s4_mode", 64'(app_mode), 64'(4'b0100));
        for (int i = 0; i < BLINK - 1; i++) apply_stimulus("s4_hold", B_NONE, 4'b1010);
        apply_stimulus("s4_off", B_NONE, 4'b1010);
        check_output("s4_blank", 64'(out), 64'({DW{1'b1}}));
        for (int i = 0; i < BLINK; i++) apply_stimulus("s4_hold2", B_NONE, 4'b1010);
        apply_stimulus("s4_ack", B_ENTER, 4'b1010);
        check_output("s4_enter", 64'(app_enter), 64'(4'b0010));
        check_output("s4_norm", 64'(norm), 64'(1'b1));
        apply_stimulus("s4_clr", B_NONE, 4'b0000);

        apply_stimulus("s5_esc", B_ESC, 4'b0000);
        apply_stimulus("s5_entalm", B_ENTER, 4'b1000);
        check_output("s5_nomode", 64'(app_mode), 64'(4'b0000));
        check_output("s5_alarm", 64'(alarm), 64'(1'b1));
        apply_stimulus("s5_drop", B_NONE, 4'b0000);
        check_output("s5_menu", 64'(out[7:0]), 64'(8'hA4));
        check_output("s5_alarm0", 64'(alarm), 64'(1'b0));

        apply_stimulus("s6_alm", B_NONE, 4'b0100);
        rst_n = 1'b0;
        apply_stimulus("s6_rst", B_NONE, 4'b0100);
        check_output("s6_out", 64'(out), 64'({{(DW-8){1'b1}}, 8'hC0}));
        check_output("s6_alarm", 64'(alarm), 64'(1'b0));
        rst_n = 1'b1;
        apply_stimulus("s6_idle", B_NONE, 4'b0000);

        ra = '0;
        for (int n = 0; n < 800; n++) begin
            rb = B_NONE;
            if ($urandom_range(0, 2) == 0) rb[$urandom_range(0, 5)] = 1'b1;
            if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, 5)] = 1'b1;
            if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, NA-1)] ^= 1'b1;
            rst_n = ($urandom_range(0, 299) != 0);
            apply_stimulus("rnd", rb, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
